// File: rtl/uart_if.sv
// Host-side and serial-pin signals of the 8N1 UART, grouped for a single port.
interface uart_if;
  logic [7:0] data_send;
  logic       wr_en;
  logic       tx;
  logic       tx_busy;
  logic       rx;
  logic       rdy;
  logic       rdy_clr;
  logic [7:0] received_data;

  modport master (
    output data_send, wr_en, rx, rdy_clr,
    input  tx, tx_busy, rdy, received_data
  );

  modport slave (
    input  data_send, wr_en, rx, rdy_clr,
    output tx, tx_busy, rdy, received_data
  );
endinterface

// File: rtl/uart.sv
// Minimal 8N1 UART: independent TX and 16x-oversampled RX sharing one baud divider setting.
// TX is busy for 10 bit-times per accepted byte; RX raises rdy at mid-stop-bit.
module uart #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic clk,
  input  logic rst_n,
  uart_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int RX_TICK_DIV  = CLK_FREQ / (16 * BAUD);
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int TW           = $clog2(RX_TICK_DIV) + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_shift;
  logic          r_tx;
  logic          r_tx_busy;
  logic          w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (bus.wr_en) begin
            r_tx_shift <= bus.data_send;
            r_tx_cnt   <= '0;
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_idx   <= r_tx_idx + 3'd1;
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.tx      = r_tx;
  assign bus.tx_busy = r_tx_busy;

  logic          r_rx_s1;
  logic          r_rx_s2;
  logic [TW-1:0] r_div;
  logic          w_tick;

  assign w_tick = (r_div == TW'(RX_TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_div   <= '0;
    end else begin
      r_rx_s1 <= bus.rx;
      r_rx_s2 <= r_rx_s1;
      r_div   <= w_tick ? '0 : r_div + TW'(1);
    end
  end

  rx_state_t  r_rx_state;
  logic [3:0] r_rx_tcnt;
  logic [2:0] r_rx_idx;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_rdy;
  logic       r_wait_high;

  // Set of rdy is written after the clear so a coinciding completion wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_rx_tcnt   <= '0;
      r_rx_idx    <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rdy       <= 1'b0;
      r_wait_high <= 1'b0;
    end else begin
      if (bus.rdy_clr) r_rdy <= 1'b0;
      if (w_tick) begin
        case (r_rx_state)
          RX_IDLE: begin
            if (r_wait_high) begin
              if (r_rx_s2) r_wait_high <= 1'b0;
            end else if (!r_rx_s2) begin
              r_rx_tcnt  <= '0;
              r_rx_state <= RX_START;
            end
          end
          RX_START: begin
            if (r_rx_tcnt == 4'd7) begin
              r_rx_tcnt  <= '0;
              r_rx_idx   <= '0;
              r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 4'd1;
            end
          end
          RX_DATA: begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
            if (r_rx_tcnt == 4'd15) begin
              r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
              r_rx_idx   <= r_rx_idx + 3'd1;
              if (r_rx_idx == 3'd7) r_rx_state <= RX_STOP;
            end
          end
          RX_STOP: begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
            if (r_rx_tcnt == 4'd15) begin
              if (r_rx_s2) begin
                r_rx_data <= r_rx_shift;
                r_rdy     <= 1'b1;
              end else begin
                r_wait_high <= 1'b1;
              end
              r_rx_state <= RX_IDLE;
            end
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign bus.rdy           = r_rdy;
  assign bus.received_data = r_rx_data;

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart at CLKS_PER_BIT=16, one RX tick per clock.
module tb_uart;
  logic clk = 1'b0;
  logic rst_n;
  logic lb_en;
  logic rx_drv;

  always #5 clk = ~clk;

  uart_if bus ();
  assign bus.rx = lb_en ? bus.tx : rx_drv;

  uart #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a byte is presented when rdy rises or data changes while rdy holds.
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  logic [7:0] exp_b;
  always @(negedge clk) begin
    if (bus.rdy === 1'b1 && (!prev_rdy || bus.received_data != prev_dat)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rx_spurious: got %0h expected no byte", bus.received_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (bus.received_data !== exp_b) begin
          n_err++;
          $display("FAIL rx_byte: got %0h expected %0h", bus.received_data, exp_b);
        end
      end
    end
    prev_rdy = bus.rdy;
    prev_dat = bus.received_data;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.data_send = b;
    bus.wr_en     = 1'b1;
    @(negedge clk);
    bus.wr_en     = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.tx_busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (bus.tx_busy) check("tx_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_rdy_clr();
    int t = 0;
    while (!bus.rdy && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rdy) check("rdy_timeout", 32'd0, 32'd1);
    bus.rdy_clr = 1'b1;
    @(negedge clk);
    bus.rdy_clr = 1'b0;
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(16);
    end
    rx_drv = stop;
    tick(16);
  endtask

  logic       tx_w [0:199];
  int         busy_cnt;
  int         first_low;
  logic [9:0] fr;

  initial begin
    bus.data_send = 8'h00;
    bus.wr_en     = 1'b0;
    bus.rdy_clr   = 1'b0;
    lb_en         = 1'b1;
    rx_drv        = 1'b1;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_busy", 32'(bus.tx_busy), 32'd0);
    check("reset_rdy", 32'(bus.rdy), 32'd0);
    check("reset_data", 32'(bus.received_data), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // TX waveform of 0x55, index i is the sample after the i-th edge from accept.
    exp_q.push_back(8'h55);
    write_byte(8'h55);
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tx_w[i] = bus.tx;
      busy_cnt += int'(bus.tx_busy);
      @(negedge clk);
    end
    fr = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) check($sformatf("tx55_bit%0d", k), 32'(tx_w[16*k+8]), 32'(fr[k]));
    check("tx55_start_last", 32'(tx_w[15]), 32'd0);
    check("tx55_bit0_first", 32'(tx_w[16]), 32'd1);
    check("tx55_busy_len", 32'(busy_cnt), 32'd160);
    wait_rdy_clr();

    // Writes while busy (mid-frame and in the final busy cycle) are dropped.
    wait_idle();
    exp_q.push_back(8'h0F);
    write_byte(8'h0F);
    busy_cnt  = 0;
    first_low = -1;
    for (int i = 0; i < 200; i++) begin
      busy_cnt += int'(bus.tx_busy);
      if (!bus.tx_busy && first_low < 0) first_low = i;
      if (i == 40)  begin bus.data_send = 8'hAA; bus.wr_en = 1'b1; end
      if (i == 41)  bus.wr_en = 1'b0;
      if (i == 159) bus.wr_en = 1'b1;
      if (i == 160) bus.wr_en = 1'b0;
      @(negedge clk);
    end
    check("ign_busy_len", 32'(busy_cnt), 32'd160);
    check("ign_first_idle", 32'(first_low), 32'd160);
    check("ign_no_restart", 32'(bus.tx_busy), 32'd0);
    wait_rdy_clr();

    // All-byte loopback, each write one cycle after tx_busy drops.
    for (int b = 0; b < 256; b++) begin
      wait_idle();
      exp_q.push_back(8'(b));
      write_byte(8'(b));
      wait_rdy_clr();
    end

    // Glitch and framing error on a directly driven rx.
    wait_idle();
    lb_en  = 1'b0;
    rx_drv = 1'b1;
    tick(5);
    rx_drv = 1'b0;
    tick(3);
    rx_drv = 1'b1;
    tick(300);
    check("glitch_rdy", 32'(bus.rdy), 32'd0);
    check("glitch_data", 32'(bus.received_data), 32'hFF);
    send_rx_frame(8'h5A, 1'b0);
    tick(32);
    rx_drv = 1'b1;
    tick(40);
    check("frame_err_rdy", 32'(bus.rdy), 32'd0);
    check("frame_err_data", 32'(bus.received_data), 32'hFF);

    // Overwrite without clear, then clear coinciding with completion.
    exp_q.push_back(8'h12);
    send_rx_frame(8'h12, 1'b1);
    rx_drv = 1'b1;
    tick(20);
    exp_q.push_back(8'h34);
    send_rx_frame(8'h34, 1'b1);
    rx_drv = 1'b1;
    tick(20);
    check("ovr_rdy", 32'(bus.rdy), 32'd1);
    check("ovr_data", 32'(bus.received_data), 32'h34);
    exp_q.push_back(8'h56);
    bus.rdy_clr = 1'b1;
    fork
      send_rx_frame(8'h56, 1'b1);
      begin
        for (int t = 0; t < 400; t++) begin
          if (bus.received_data == 8'h56) break;
          @(negedge clk);
        end
        bus.rdy_clr = 1'b0;
      end
    join
    rx_drv = 1'b1;
    tick(5);
    check("coinc_rdy", 32'(bus.rdy), 32'd1);
    check("coinc_data", 32'(bus.received_data), 32'h56);

    // Reset mid-frame on both TX and RX, then a clean loopback.
    lb_en = 1'b1;
    write_byte(8'hA5);
    tick(80);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(bus.tx), 32'd1);
    check("mid_rst_busy", 32'(bus.tx_busy), 32'd0);
    check("mid_rst_rdy", 32'(bus.rdy), 32'd0);
    check("mid_rst_data", 32'(bus.received_data), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    exp_q.push_back(8'hC3);
    write_byte(8'hC3);
    wait_rdy_clr();
    tick(200);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart.md
Name: uart

Overview:
- Minimal 8N1 UART: one transmitter and one receiver sharing a single clock and a compile-time baud divider.
- Byte-wide write strobe on the TX side; ready flag with explicit clear on the RX side.
- Sits between a host/register interface and the serial pins.
- TX and RX are fully independent, so tx can be looped back to rx for self-test.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- Derived: CLKS_PER_BIT = CLK_FREQ/BAUD, integer, must be >=16.
- Derived: RX_TICK_DIV = CLK_FREQ/(16*BAUD), integer, must be >=1. This is the RX 16x oversample tick period in clocks.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- data_send, input, 8, byte to transmit; sampled on an accepted wr_en.
- wr_en, input, 1, one-cycle write strobe.
- tx, output, 1, serial out; idles high.
- tx_busy, output, 1, high while a frame is being sent.
- rx, input, 1, serial in; asynchronous to clk.
- rdy, output, 1, high when received_data holds an unread byte.
- rdy_clr, input, 1, synchronous clear of rdy.
- received_data, output, 8, last correctly framed received byte.

Behaviour:
- Reset (rst_n low, async): tx=1, tx_busy=0, rdy=0, received_data=0. Both FSMs go to IDLE and all counters clear.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM states: IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
- TX accept: wr_en high in IDLE latches data_send. On the next edge, tx_busy=1 and tx=0 (START), and the bit counter restarts.
- TX bit width: each bit is held exactly CLKS_PER_BIT clocks, so the full frame is 10*CLKS_PER_BIT clocks.
- TX completion: after the stop bit's CLKS_PER_BIT clocks, return to IDLE and tx_busy=0. A wr_en in that same cycle (while still busy) is ignored; a wr_en one cycle later is accepted.
- wr_en while tx_busy=1 is ignored; it neither corrupts nor queues a byte. Changes to data_send after acceptance have no effect on the frame.
- RX input: rx passes through a 2-flop synchronizer. A free-running divider produces a one-clock tick every RX_TICK_DIV clocks (16x oversample).
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: the synchronized rx going low on a tick moves to START, with the tick count cleared.
  - START: at tick count 8 (mid-bit), if rx is still low go to DATA; otherwise it was a false start (glitch) and returns to IDLE with no side effects.
  - DATA: sample every 16 ticks and shift LSB first. After 8 bits go to STOP.
  - STOP: sample 16 ticks later. If rx=1, load received_data and set rdy=1 on the same edge, then go to IDLE. If rx=0 (framing error), discard the byte, leave rdy and received_data unchanged, and go to IDLE; a new start is accepted only after rx returns high.
- rdy handshake:
  - rdy stays high until a clock edge with rdy_clr=1, which clears it.
  - If a new byte completes while rdy=1, received_data is overwritten and rdy stays 1 (no overrun flag).
  - If byte completion and rdy_clr coincide, the set wins: rdy=1 with the new data.
- received_data is stable except on a valid stop-bit edge.
- Loopback (tx tied to rx): every byte written is received unchanged, with rdy rising about 9.5 bit-times after acceptance.
- Reset asserted mid-frame: tx goes high immediately, the partial RX byte is dropped, and the next frame after reset release is handled normally.

Test Plan:
- All-byte loopback (CLK_FREQ=1600, BAUD=100, i.e. CLKS_PER_BIT=16, RX_TICK_DIV=1; tx tied to rx): write 0x00, then on each rdy pulse pulse rdy_clr, check received_data == sent byte and write byte+1, up to 0xFF -> all 256 match, with no spurious rdy.
- TX waveform, write 0x55: tx stays low 16 clocks after the accept edge, then bits 1,0,1,0,1,0,1,0 at 16 clocks each, then high for 16 clocks. tx_busy is high for exactly 160 clocks.
- wr_en pulse with 0xAA while sending 0x0F -> only 0x0F appears on tx and is received; tx_busy never deasserts early.
- rx glitch low for 3 clocks in IDLE -> no rdy, and RX returns to IDLE. A frame with stop bit 0 -> rdy stays 0 and received_data is unchanged.
- Two frames 0x12, 0x34 without rdy_clr -> rdy stays 1 and received_data=0x34. rdy_clr coinciding with completion of a third byte 0x56 -> rdy=1 and received_data=0x56.
- Assert rst_n low mid-TX and mid-RX -> tx=1, tx_busy=0, rdy=0, received_data=0 immediately. After release, sending 0xC3 loops back correctly.
